vga_scanout: RTL and testbench

- Parametrised successor to the fixed 1280x800 scan-out block: VGA timing generator, double-buffered frame read, palette lookup and sync/data alignment, all in one clock domain.
- The page flip is requested by the writer and taken only at vblank, so a frame is never swapped mid-scan and an unfinished page is never shown.
- The frame RAM is external; this block drives its read port and receives pixel indices after a fixed latency.

---
 rtl/vga_pkg.sv | 47 ++++
 rtl/vga_palette.sv | 37 +++
 rtl/vga_scanout.sv | 250 +++++++++++++++++++++++++
 tb/tb_vga_scanout.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared types, palette table and 1280x800@60 timing defaults
// for the vga_scanout slice.
package vga_pkg;

    // 1280x800@60 timing and frame-window defaults
    localparam int DEF_COOR_WIDTH  = 12;
    localparam int DEF_HSIZE       = 1280;
    localparam int DEF_HFP         = 1344;
    localparam int DEF_HSP         = 1480;
    localparam int DEF_HMAX        = 1680;
    localparam int DEF_VSIZE       = 800;
    localparam int DEF_VFP         = 801;
    localparam int DEF_VSP         = 804;
    localparam int DEF_VMAX        = 828;
    localparam int DEF_PIX_BITS    = 2;
    localparam int DEF_ADDR_WIDTH  = 20;

    // Pixel index as stored in the frame RAM
    typedef logic [DEF_PIX_BITS-1:0] pix_idx_t;

    // Packed 8:8:8 colour, red in the top byte
    typedef logic [23:0] rgb_t;

    // Video control bits carried down the alignment pipeline (active-high
    // internally; sync polarity is applied at the output register)
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic inf;
    } vid_ctl_t;

    // Four-entry palette; index 0 is deliberately not black so that the
    // blanking of non-frame pixels is distinguishable from a zero index
    localparam rgb_t PALETTE [4] = '{
        24'h1F3F5F,
        24'hFFFFFF,
        24'hFF8000,
        24'h0080FF
    };

    // Wider indices wrap onto the four-entry table
    function automatic rgb_t palette_rgb(input logic [1:0] idx);
        return PALETTE[idx];
    endfunction

endpackage

// File: rtl/vga_palette.sv
// vga_palette: registered index-to-RGB lookup using the vga_pkg table.
// Output is forced to black when i_enable is low.
module vga_palette
    import vga_pkg::*;
#(
    parameter int PIX_BITS = 2
) (
    input  logic                clk_vga,
    input  logic                rst_n,
    input  logic [PIX_BITS-1:0] i_index,
    input  logic                i_enable,
    output logic [7:0]          o_red,
    output logic [7:0]          o_green,
    output logic [7:0]          o_blue
);

    logic [1:0] w_sel;
    rgb_t       r_rgb;

    assign w_sel = 2'(i_index);

    // Register the looked-up colour, or black outside the frame window
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb <= '0;
        end else if (i_enable) begin
            r_rgb <= palette_rgb(w_sel);
        end else begin
            r_rgb <= '0;
        end
    end

    assign o_red   = r_rgb[23:16];
    assign o_green = r_rgb[15:8];
    assign o_blue  = r_rgb[7:0];

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing, double-buffered frame read, palette lookup and
// sync/data alignment in one clock domain. Page flips are taken only at the
// swap point (v==VSIZE, h==0). Optional macro VGA_SCALE2_EN shows each
// stored pixel as a 2x2 block.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int COOR_WIDTH   = DEF_COOR_WIDTH,
    parameter int HSIZE        = DEF_HSIZE,
    parameter int HFP          = DEF_HFP,
    parameter int HSP          = DEF_HSP,
    parameter int HMAX         = DEF_HMAX,
    parameter int VSIZE        = DEF_VSIZE,
    parameter int VFP          = DEF_VFP,
    parameter int VSP          = DEF_VSP,
    parameter int VMAX         = DEF_VMAX,
    parameter bit HSPP         = 1'b1,
    parameter bit VSPP         = 1'b1,
    parameter int FRAME_LEFT   = 0,
    parameter int FRAME_RIGHT  = 1280,
    parameter int FRAME_TOP    = 250,
    parameter int FRAME_BOTTOM = 550,
    parameter int PIX_BITS     = DEF_PIX_BITS,
    parameter int RD_LATENCY   = 1,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
    input  logic                  clk_vga,
    input  logic                  rst_n,
    input  logic                  flip_req,
    output logic                  flip_ack,
    output logic                  write_page,
    output logic [15:0]           frame_count,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [PIX_BITS-1:0]   rd_data,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  data_enable,
    output logic [7:0]            out_red,
    output logic [7:0]            out_green,
    output logic [7:0]            out_blue
);

    localparam int FRAME_W = FRAME_RIGHT - FRAME_LEFT;
    localparam int FRAME_H = FRAME_BOTTOM - FRAME_TOP;
`ifdef VGA_SCALE2_EN
    localparam int PAGE_SIZE = (FRAME_W * FRAME_H) / 4;
`else
    localparam int PAGE_SIZE = FRAME_W * FRAME_H;
`endif
    localparam logic [ADDR_WIDTH-1:0] PAGE_BASE = ADDR_WIDTH'(PAGE_SIZE);

    // Reject timing/window combinations the datapath cannot handle
    if (FRAME_RIGHT > HSIZE || FRAME_LEFT >= FRAME_RIGHT) begin : g_bad_hwin
        $error("vga_scanout: bad horizontal frame window");
    end
    if (FRAME_BOTTOM > VSIZE || FRAME_TOP >= FRAME_BOTTOM) begin : g_bad_vwin
        $error("vga_scanout: bad vertical frame window");
    end
    if (!(HSIZE < HFP && HFP < HSP && HSP <= HMAX)) begin : g_bad_htim
        $error("vga_scanout: bad horizontal timing");
    end
    if (!(VSIZE < VFP && VFP < VSP && VSP <= VMAX)) begin : g_bad_vtim
        $error("vga_scanout: bad vertical timing");
    end
    if ((longint'(2) * PAGE_SIZE) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_addr
        $error("vga_scanout: two pages do not fit the address space");
    end
    if (RD_LATENCY < 1) begin : g_bad_lat
        $error("vga_scanout: RD_LATENCY must be at least 1");
    end
`ifdef VGA_SCALE2_EN
    if ((FRAME_W % 2) != 0 || (FRAME_H % 2) != 0) begin : g_bad_scale
        $error("vga_scanout: 2x2 scaling needs an even frame size");
    end
`endif

    logic [COOR_WIDTH-1:0] r_h;
    logic [COOR_WIDTH-1:0] r_v;
    int                    w_hi;
    int                    w_vi;
    logic                  w_in_frame;
    logic                  w_swap;
    logic [ADDR_WIDTH-1:0] w_base;

    logic                  r_read_page;
    logic [15:0]           r_frame_count;
    logic                  r_flip_ack;

    logic [ADDR_WIDTH-1:0] r_offset;
    logic [ADDR_WIDTH-1:0] r_rd_addr;

    vid_ctl_t              r_s0;
    vid_ctl_t              r_dly [RD_LATENCY];
    vid_ctl_t              w_aligned;

    logic                  r_hsync;
    logic                  r_vsync;
    logic                  r_de;

    assign w_hi       = int'(r_h);
    assign w_vi       = int'(r_v);
    assign w_in_frame = (w_hi >= FRAME_LEFT) && (w_hi < FRAME_RIGHT) &&
                        (w_vi >= FRAME_TOP)  && (w_vi < FRAME_BOTTOM);
    assign w_swap     = (w_vi == VSIZE) && (w_hi == 0);
    assign w_base     = r_read_page ? PAGE_BASE : '0;

`ifdef VGA_SCALE2_EN
    localparam bit FL_ODD = (FRAME_LEFT % 2) == 1;
    localparam bit FT_ODD = (FRAME_TOP % 2) == 1;

    logic                  w_h_odd;
    logic                  w_v_odd;
    logic                  w_last_col;
    logic [ADDR_WIDTH-1:0] r_line_start;

    assign w_h_odd    = r_h[0] ^ FL_ODD;
    assign w_v_odd    = r_v[0] ^ FT_ODD;
    assign w_last_col = (w_hi == FRAME_RIGHT - 1);
`endif

    // Free-running raster position: h wraps every line, v on each h wrap
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_hi == HMAX - 1) begin
            r_h <= '0;
            if (w_vi == VMAX - 1) begin
                r_v <= '0;
            end else begin
                r_v <= r_v + 1'b1;
            end
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    // Page swap and frame counting at the swap point; ack follows one cycle later
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            r_read_page   <= 1'b0;
            r_frame_count <= '0;
            r_flip_ack    <= 1'b0;
        end else begin
            r_flip_ack <= w_swap && flip_req;
            if (w_swap) begin
                r_frame_count <= r_frame_count + 1'b1;
                if (flip_req) begin
                    r_read_page <= ~r_read_page;
                end
            end
        end
    end

    // Stage 0: decode sync/active/frame windows from the raster position
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            r_s0 <= '0;
        end else begin
            r_s0.hs  <= (w_hi >= HFP) && (w_hi < HSP);
            r_s0.vs  <= (w_vi >= VFP) && (w_vi < VSP);
            r_s0.de  <= (w_hi < HSIZE) && (w_vi < VSIZE);
            r_s0.inf <= w_in_frame;
        end
    end

    // Read address: page base plus an offset walked incrementally per frame pixel
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            r_offset  <= '0;
            r_rd_addr <= '0;
`ifdef VGA_SCALE2_EN
            r_line_start <= '0;
`endif
        end else if (w_swap) begin
            r_offset <= '0;
`ifdef VGA_SCALE2_EN
            r_line_start <= '0;
`endif
        end else if (w_in_frame) begin
            r_rd_addr <= w_base + r_offset;
`ifdef VGA_SCALE2_EN
            if (w_last_col) begin
                if (w_v_odd) begin
                    r_offset     <= r_offset + 1'b1;
                    r_line_start <= r_offset + 1'b1;
                end else begin
                    r_offset <= r_line_start;
                end
            end else if (w_h_odd) begin
                r_offset <= r_offset + 1'b1;
            end
`else
            r_offset <= r_offset + 1'b1;
`endif
        end
    end

    // Delay the control bits so they line up with rd_data
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_dly[i] <= '0;
            end
        end else begin
            r_dly[0] <= r_s0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign w_aligned = r_dly[RD_LATENCY-1];

    // Output register for sync/enable, matching the palette register stage
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync <= ~HSPP;
            r_vsync <= ~VSPP;
            r_de    <= 1'b0;
        end else begin
            r_hsync <= w_aligned.hs ? HSPP : ~HSPP;
            r_vsync <= w_aligned.vs ? VSPP : ~VSPP;
            r_de    <= w_aligned.de;
        end
    end

    vga_palette #(
        .PIX_BITS (PIX_BITS)
    ) u_palette (
        .clk_vga  (clk_vga),
        .rst_n    (rst_n),
        .i_index  (rd_data),
        .i_enable (w_aligned.inf),
        .o_red    (out_red),
        .o_green  (out_green),
        .o_blue   (out_blue)
    );

    assign flip_ack    = r_flip_ack;
    assign write_page  = ~r_read_page;
    assign frame_count = r_frame_count;
    assign rd_en       = r_s0.inf;
    assign rd_addr     = r_rd_addr;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign data_enable = r_de;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: small-raster bench for vga_scanout (8x4 visible, 12x7 total,
// full-area frame, RD_LATENCY=1). A raster-position model predicts every
// output each cycle; directed literals pin the model at known cycles.
module tb_vga_scanout;

    localparam int TH = 8, THFP = 9, THSP = 10, THMAX = 12;
    localparam int TV = 4, TVFP = 5, TVSP = 6, TVMAX = 7;
    localparam int FL = 0, FR = 8, FT = 0, FB = 4;
    localparam int FW = FR - FL;
    localparam int TOTAL = THMAX * TVMAX;
    localparam int SWAP_POS = TV * THMAX;
`ifdef VGA_SCALE2_EN
    localparam int PAGE = (FW * (FB - FT)) / 4;
`else
    localparam int PAGE = FW * (FB - FT);
`endif

    logic        clk_vga;
    logic        rst_n;
    logic        flip_req;
    logic        flip_ack;
    logic        write_page;
    logic [15:0] frame_count;
    logic        rd_en;
    logic [19:0] rd_addr;
    logic [1:0]  rd_data;
    logic        hsync;
    logic        vsync;
    logic        data_enable;
    logic [7:0]  out_red;
    logic [7:0]  out_green;
    logic [7:0]  out_blue;

    int errors = 0;
    int checks = 0;

    int n = 0;
    int mPage = 0;
    int mFrames = 0;
    bit mAck = 0;

    logic [23:0] PAL [4];

    vga_scanout #(
        .COOR_WIDTH(12), .HSIZE(TH), .HFP(THFP), .HSP(THSP), .HMAX(THMAX),
        .VSIZE(TV), .VFP(TVFP), .VSP(TVSP), .VMAX(TVMAX), .HSPP(1'b1), .VSPP(1'b1),
        .FRAME_LEFT(FL), .FRAME_RIGHT(FR), .FRAME_TOP(FT), .FRAME_BOTTOM(FB),
        .PIX_BITS(2), .RD_LATENCY(1), .ADDR_WIDTH(20)
    ) dut (
        .clk_vga(clk_vga), .rst_n(rst_n), .flip_req(flip_req), .flip_ack(flip_ack),
        .write_page(write_page), .frame_count(frame_count), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .hsync(hsync), .vsync(vsync),
        .data_enable(data_enable), .out_red(out_red), .out_green(out_green),
        .out_blue(out_blue)
    );

    initial clk_vga = 1'b0;
    always #5 clk_vga = ~clk_vga;

    // Frame RAM contents; address 19 (pixel 3,2 of page 0) holds index 1
    function automatic logic [1:0] ramPix(input logic [19:0] a);
        if (a == 20'd19) return 2'd1;
        return 2'((a * 3) ^ (a >> 3));
    endfunction

    // Frame RAM read port with one cycle of latency
    always @(posedge clk_vga) rd_data <= ramPix(rd_addr);

    function automatic bit inFrame(input int h, input int v);
        return (h >= FL) && (h < FR) && (v >= FT) && (v < FB);
    endfunction

    function automatic int pixOffset(input int h, input int v);
`ifdef VGA_SCALE2_EN
        return ((v - FT) / 2) * (FW / 2) + (h - FL) / 2;
`else
        return (v - FT) * FW + (h - FL);
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at n=%0d: got %0h, expected %0h", name, n, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit flip);
        flip_req = flip;
    endtask

    // Frame-level model: n counts clock edges since reset release; swaps,
    // page and acks follow from the raster position before each edge
    always @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            n = 0; mPage = 0; mFrames = 0; mAck = 0;
        end else begin
            mAck = 0;
            if ((n % TOTAL) == SWAP_POS) begin
                mFrames = (mFrames + 1) % 65536;
                if (flip_req) begin
                    mPage = 1 - mPage;
                    mAck = 1;
                end
            end
            n = n + 1;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk_vga) begin
        if (rst_n) begin
            int p, h, v, addr;
            bit expRdEn, expHs, expVs, expDe, expIn;
            logic [23:0] expRgb;
            expRdEn = 0; addr = 0;
            if (n >= 1) begin
                p = (n - 1) % TOTAL; h = p % THMAX; v = p / THMAX;
                expRdEn = inFrame(h, v);
                addr = mPage * PAGE + pixOffset(h, v);
            end
            checkOutput("rd_en", 32'(rd_en), 32'(expRdEn));
            if (expRdEn) checkOutput("rd_addr", 32'(rd_addr), 32'(addr));
            expHs = 0; expVs = 0; expDe = 0; expRgb = 24'h0;
            if (n >= 3) begin
                p = (n - 3) % TOTAL; h = p % THMAX; v = p / THMAX;
                expHs = (h >= THFP) && (h < THSP);
                expVs = (v >= TVFP) && (v < TVSP);
                expDe = (h < TH) && (v < TV);
                expIn = inFrame(h, v);
                if (expIn) expRgb = PAL[ramPix(20'(mPage * PAGE + pixOffset(h, v)))];
            end
            checkOutput("hsync", 32'(hsync), 32'(expHs));
            checkOutput("vsync", 32'(vsync), 32'(expVs));
            checkOutput("data_enable", 32'(data_enable), 32'(expDe));
            checkOutput("rgb", {8'h0, out_red, out_green, out_blue}, {8'h0, expRgb});
            checkOutput("frame_count", 32'(frame_count), 32'(mFrames));
            checkOutput("flip_ack", 32'(flip_ack), 32'(mAck));
            checkOutput("write_page", 32'(write_page), 32'(1 - mPage));
        end
    end

    task automatic checkResetValues();
        checkOutput("reset_hsync", 32'(hsync), 32'd0);
        checkOutput("reset_vsync", 32'(vsync), 32'd0);
        checkOutput("reset_de", 32'(data_enable), 32'd0);
        checkOutput("reset_rgb", {8'h0, out_red, out_green, out_blue}, 32'd0);
        checkOutput("reset_rd_en", 32'(rd_en), 32'd0);
        checkOutput("reset_rd_addr", 32'(rd_addr), 32'd0);
        checkOutput("reset_flip_ack", 32'(flip_ack), 32'd0);
        checkOutput("reset_frame_count", 32'(frame_count), 32'd0);
        checkOutput("reset_write_page", 32'(write_page), 32'd1);
    endtask

    task automatic applyReset();
        @(negedge clk_vga);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_vga);
        checkResetValues();
        rst_n = 1'b1;
    endtask

    initial begin
        int firstHs, hsCount, vsCount, deCount, rdCount, addrBad, ackCount, firstAck, addr85;
        PAL[0] = 24'h1F3F5F; PAL[1] = 24'hFFFFFF; PAL[2] = 24'hFF8000; PAL[3] = 24'h0080FF;
        rst_n = 1'b0;
        flip_req = 1'b0;
        applyReset();

        // Frame 0 with flip_req low: timing counts and read order
        firstHs = -1; hsCount = 0; vsCount = 0; deCount = 0; rdCount = 0; addrBad = 0; ackCount = 0;
        for (int k = 0; k < 84; k++) begin
            @(negedge clk_vga);
            if (hsync) begin
                hsCount++;
                if (firstHs < 0) firstHs = n;
            end
            if (vsync) vsCount++;
            if (data_enable) deCount++;
            if (rd_en) begin
                if (int'(rd_addr) != rdCount) addrBad++;
                rdCount++;
            end
            if (flip_ack) ackCount++;
            if (n == 30) begin
                checkOutput("pix32_rgb", {8'h0, out_red, out_green, out_blue}, 32'h00FFFFFF);
                checkOutput("pix32_de", 32'(data_enable), 32'd1);
            end
            if (n == 11) checkOutput("blank_rgb", {8'h0, out_red, out_green, out_blue}, 32'd0);
            if (n == 50) checkOutput("frame_count_first", 32'(frame_count), 32'd1);
        end
        checkOutput("first_hsync_n", 32'(firstHs), 32'd12);
        checkOutput("hsync_pulses", 32'(hsCount), 32'd7);
        checkOutput("vsync_cycles", 32'(vsCount), 32'd12);
        checkOutput("de_cycles", 32'(deCount), 32'd32);
        checkOutput("rd_en_cycles", 32'(rdCount), 32'd32);
        checkOutput("rd_addr_order", 32'(addrBad), 32'd0);

        // Two more frames without a flip request, then reset mid-frame
        for (int k = 0; k < 186; k++) begin
            @(negedge clk_vga);
            if (flip_ack) ackCount++;
        end
        checkOutput("no_flip_acks", 32'(ackCount), 32'd0);
        checkOutput("no_flip_write_page", 32'(write_page), 32'd1);
        checkOutput("no_flip_frames", 32'(frame_count), 32'd3);
        applyStimulus(1'b1);
        applyReset();
        applyStimulus(1'b0);

        // Flip requested mid-frame 0, dropped on the ack
        ackCount = 0; firstAck = -1; addr85 = -1;
        for (int k = 0; k < 170; k++) begin
            @(negedge clk_vga);
            if (n == 20) applyStimulus(1'b1);
            if (flip_ack) begin
                ackCount++;
                if (firstAck < 0) firstAck = n;
                applyStimulus(1'b0);
            end
            if (n == 85 && rd_en) addr85 = int'(rd_addr);
            if (n == 100) checkOutput("flip_write_page", 32'(write_page), 32'd0);
            if (n == 132) break;
        end
        checkOutput("flip_ack_count", 32'(ackCount), 32'd1);
        checkOutput("flip_ack_n", 32'(firstAck), 32'd49);
        checkOutput("page1_first_addr", 32'(addr85), 32'd32);

        // Request raised exactly on the swap cycle and held past the ack
        applyStimulus(1'b1);
        ackCount = 0;
        for (int k = 0; k < 128; k++) begin
            @(negedge clk_vga);
            if (flip_ack) ackCount++;
            if (n == 137) applyStimulus(1'b0);
        end
        checkOutput("swap_cycle_acks", 32'(ackCount), 32'd1);
        checkOutput("swap_cycle_write_page", 32'(write_page), 32'd1);
        checkOutput("swap_cycle_frames", 32'(frame_count), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the bench always terminates
    initial begin
        #200000;
        $display("[TB] FAIL timeout: bench did not finish within the time bound");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] timeout");
    end

endmodule
